routing_table_writer: RTL

//  Writer side of the per-router routing table. After reset, sweeps every

---
 rtl/routing_table_writer_pkg.sv | 21 ++
 rtl/routing_table_writer_xy.sv | 28 ++
 rtl/routing_table_writer.sv | 109 ++++++++++
 3 files changed

// File: rtl/routing_table_writer_pkg.sv
// Shared NoC sizing, direction encoding and FSM state type for the routing table writer.
package routing_table_writer_pkg;

  localparam int NUM_NODES = 16;
  // One spare address bit so out-of-range overrides can reach the port and be rejected.
  localparam int ADDR_BITS = 5;
  localparam int BITS_DIR  = 3;

  localparam logic [BITS_DIR-1:0] DIR_NORTH = 3'd0;
  localparam logic [BITS_DIR-1:0] DIR_EAST  = 3'd1;
  localparam logic [BITS_DIR-1:0] DIR_SOUTH = 3'd2;
  localparam logic [BITS_DIR-1:0] DIR_WEST  = 3'd3;
  localparam logic [BITS_DIR-1:0] DIR_LOCAL = 3'd4;

  typedef enum logic {INIT, RUN} state_t;

  function automatic logic dir_is_legal(input logic [BITS_DIR-1:0] dir);
    return dir <= DIR_LOCAL;
  endfunction

endpackage

// File: rtl/routing_table_writer_xy.sv
// Combinational dimension-ordered (X first, then Y) output direction for one destination.
module xy_route_calc
  import routing_table_writer_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int MESH_COLS = 4
) (
  input  logic [ADDR_BITS-1:0] dest,
  output logic [BITS_DIR-1:0]  dir
);

  localparam int SELF_X = NODE_ID % MESH_COLS;
  localparam int SELF_Y = NODE_ID / MESH_COLS;

  int dest_x;
  int dest_y;

  always_comb begin
    dest_x = int'(dest) % MESH_COLS;
    dest_y = int'(dest) / MESH_COLS;
    if (dest_x > SELF_X)      dir = DIR_EAST;
    else if (dest_x < SELF_X) dir = DIR_WEST;
    else if (dest_y > SELF_Y) dir = DIR_SOUTH;
    else if (dest_y < SELF_Y) dir = DIR_NORTH;
    else                      dir = DIR_LOCAL;
  end

endmodule

// File: rtl/routing_table_writer.sv
// Fills the routing table with XY routes after reset or restore, then applies
// validated runtime overrides arriving on the valid/ready config port.
module routing_table_writer
  import routing_table_writer_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int MESH_COLS = 4,
  parameter int MESH_ROWS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ADDR_BITS-1:0] cfg_addr,
  input  logic [BITS_DIR-1:0]  cfg_dir,
  input  logic                 cfg_restore,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [BITS_DIR-1:0]  wr_data,
  output logic                 init_done,
  output logic                 cfg_err
);

  // Mesh area equals NUM_NODES; the sweep ends on an explicit compare, never on wrap.
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(MESH_COLS * MESH_ROWS - 1);

  state_t                 state, state_next;
  logic [ADDR_BITS-1:0]   idx, idx_next;
  logic [BITS_DIR-1:0]    sweep_dir;
  logic                   wr_en_next, init_done_next, cfg_err_next;
  logic [ADDR_BITS-1:0]   wr_addr_next;
  logic [BITS_DIR-1:0]    wr_data_next;
  logic                   cfg_legal;

  xy_route_calc #(
    .NODE_ID   (NODE_ID),
    .MESH_COLS (MESH_COLS)
  ) u_xy (
    .dest (idx),
    .dir  (sweep_dir)
  );

  assign cfg_ready = (state == RUN) & ~cfg_restore & ~reset;
  assign cfg_legal = (int'(cfg_addr) < NUM_NODES) && dir_is_legal(cfg_dir);

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr;
    wr_data_next   = wr_data;
    init_done_next = init_done;
    cfg_err_next   = 1'b0;
    case (state)
      INIT: begin
        wr_en_next   = 1'b1;
        wr_addr_next = idx;
        wr_data_next = sweep_dir;
        if (idx == LAST_IDX) begin
          state_next = RUN;
          idx_next   = '0;
        end else begin
          idx_next = idx + ADDR_BITS'(1);
        end
      end
      RUN: begin
        // Restore wins over a simultaneous request because cfg_ready is already low.
        if (cfg_restore) begin
          state_next     = INIT;
          idx_next       = '0;
          init_done_next = 1'b0;
        end else begin
          init_done_next = 1'b1;
          if (cfg_valid && cfg_ready) begin
            if (cfg_legal) begin
              wr_en_next   = 1'b1;
              wr_addr_next = cfg_addr;
              wr_data_next = cfg_dir;
            end else begin
              cfg_err_next = 1'b1;
            end
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      idx       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      wr_en     <= wr_en_next;
      wr_addr   <= wr_addr_next;
      wr_data   <= wr_data_next;
      init_done <= init_done_next;
      cfg_err   <= cfg_err_next;
    end
  end

endmodule
